// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift/add multiply and restoring divide,
// one result bit per cycle over XLEN cycles, with registered result and zero/sign flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// PREP   | operand magnitudes and result signs; divide special cases resolved
// RUN    | XLEN shift/add or shift/subtract iterations
// DONE   | rd/flags valid, done high; accepts a back-to-back start
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd,
    output logic [1:0]      flags
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic              negr_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;

    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_res;
    logic [XLEN-1:0]   wb_res;
    logic              last_iter;

    // Operand decode; a_q/b_q hold the raw operands while in PREP.
    always_comb begin
        a_signed    = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                      (op_q == OP_DIV)  || (op_q == OP_REM);
        b_signed    = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        sa          = a_signed & a_q[XLEN-1];
        sb          = b_signed & b_q[XLEN-1];
        a_mag       = sa ? -a_q : a_q;
        b_mag       = sb ? -b_q : b_q;
        div_zero    = op_q[2] && (b_q == '0);
        div_ovf     = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == SMIN) && (b_q == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op_q[1] ? a_q : '1;
        end else begin
            special_res = op_q[1] ? '0 : a_q;
        end
    end

    // One iteration. acc low half holds multiplier/dividend, high half the partial
    // product/remainder; b_q holds the multiplicand/divisor magnitude during RUN.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        acc_next = op_q[2] ? div_next : mul_next;
    end

    always_comb begin
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = negr_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      fin_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fin_res = quo;
            default:                     fin_res = rem;
        endcase
        wb_res    = (state == S_PREP) ? special_res : fin_res;
        last_iter = (cnt == CW'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            rd     <= '0;
            flags  <= 2'b01;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !flush) begin
                        state <= S_PREP;
                        op_q  <= funct3;
                        a_q   <= rs1;
                        b_q   <= rs2;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (special) begin
                        state <= S_DONE;
                        rd    <= wb_res;
                        flags <= {wb_res[XLEN-1], wb_res == '0};
                    end else begin
                        state  <= S_RUN;
                        acc    <= {{XLEN{1'b0}}, a_mag};
                        b_q    <= b_mag;
                        neg_q  <= sa ^ sb;
                        negr_q <= sa;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_next;
                        if (last_iter) begin
                            state <= S_DONE;
                            cnt   <= '0;
                            rd    <= wb_res;
                            flags <= {wb_res[XLEN-1], wb_res == '0};
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_PREP) || (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
